// File: rtl/ctrl_unit_pipe_pkg.sv
// Shared decode constants, encodings and helpers for the pipelined RV32I control unit.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } res_src_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic     reg_write;
    logic     mem_write;
    logic     branch;
    logic     jump;
    logic     jalr;
    logic     alu_src;
    logic     mdu;
    logic     illegal;
    res_src_e result_src;
    alu_op_e  alu_ctrl;
  } ctrl_t;

  // funct7 is only allowed to be all-zero, or the alternate encoding for SUB/SRA(I).
  function automatic logic f7_ok(input logic [2:0] f3, input logic [6:0] f7);
    return (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
  endfunction

  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e r;
    r = ALU_AND;
    case (f3)
      3'b000: if (alt) r = ALU_SUB; else r = ALU_ADD;
      3'b001: r = ALU_SLL;
      3'b010: r = ALU_SLT;
      3'b011: r = ALU_SLTU;
      3'b100: r = ALU_XOR;
      3'b101: if (alt) r = ALU_SRA; else r = ALU_SRL;
      3'b110: r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_unit_pipe_if.sv
// ID-stage instruction fields, hazard controls, E-stage control bundle and MDU handshake.
interface ctrl_unit_pipe_if #(parameter int ALUCTRL_W = 4);
  logic                 ValidD;
  logic [6:0]           OpD;
  logic [2:0]           funct3D;
  logic [6:0]           funct7D;
  logic                 StallE;
  logic                 FlushE;
  logic                 mdu_done;
  logic                 RegWriteE;
  logic                 MemWriteE;
  logic                 BranchE;
  logic                 JumpE;
  logic                 JalrE;
  logic                 ALUSrcE;
  logic                 MduE;
  logic                 IllegalE;
  logic [1:0]           ResultSrcE;
  logic [2:0]           ImmSrcD;
  logic [ALUCTRL_W-1:0] ALUControlE;
  logic                 mdu_start;
  logic [2:0]           mdu_op;
  logic                 mdu_abort;
  logic                 stall_req;

  // Pipeline/hazard side that presents instructions and consumes controls.
  modport master (
    output ValidD, OpD, funct3D, funct7D, StallE, FlushE, mdu_done,
    input  RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, MduE, IllegalE,
    input  ResultSrcE, ImmSrcD, ALUControlE, mdu_start, mdu_op, mdu_abort, stall_req
  );

  // Control unit side.
  modport slave (
    input  ValidD, OpD, funct3D, funct7D, StallE, FlushE, mdu_done,
    output RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, MduE, IllegalE,
    output ResultSrcE, ImmSrcD, ALUControlE, mdu_start, mdu_op, mdu_abort, stall_req
  );
endinterface

// File: rtl/ctrl_unit_pipe_decode.sv
// Pure combinational RV32I(+M) decode of the ID-stage instruction into a control bundle.
module ctrl_decode
  import rv_ctrl_pkg::*;
#(
  parameter int ENABLE_M = 1
) (
  input  logic       valid,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl,
  output imm_src_e   imm_src,
  output logic       is_m
);

  // Immediate format depends only on the opcode so the extender sees it even for bubbles.
  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_STORE:        imm_src = IMM_S;
      OP_BRANCH:       imm_src = IMM_B;
      OP_JAL:          imm_src = IMM_J;
      OP_LUI, OP_AUIPC: imm_src = IMM_U;
      default:         imm_src = IMM_I;
    endcase
  end

  // Control bundle; an illegal encoding raises only the illegal flag.
  always_comb begin
    ctrl = '0;
    is_m = 1'b0;
    if (valid) begin
      case (op)
        OP_R: begin
          if (funct7 == F7_M) begin
            if (ENABLE_M != 0) begin
              is_m           = 1'b1;
              ctrl.reg_write = 1'b1;
              ctrl.mdu       = 1'b1;
            end else begin
              ctrl.illegal = 1'b1;
            end
          end else if (f7_ok(funct3, funct7)) begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_ctrl  = alu_from_f3(funct3, funct7 == F7_ALT);
          end else begin
            ctrl.illegal = 1'b1;
          end
        end
        OP_I: begin
          // Only the shift forms carry funct7; for the rest it is immediate data.
          if (((funct3 == 3'b001) || (funct3 == 3'b101)) && !f7_ok(funct3, funct7)) begin
            ctrl.illegal = 1'b1;
          end else begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_ctrl  = alu_from_f3(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
          end
        end
        OP_LOAD: begin
          ctrl.reg_write  = 1'b1;
          ctrl.alu_src    = 1'b1;
          ctrl.result_src = RES_MEM;
        end
        OP_STORE: begin
          ctrl.mem_write = 1'b1;
          ctrl.alu_src   = 1'b1;
        end
        OP_BRANCH: begin
          ctrl.branch   = 1'b1;
          ctrl.alu_ctrl = ALU_SUB;
        end
        OP_JAL: begin
          ctrl.reg_write  = 1'b1;
          ctrl.jump       = 1'b1;
          ctrl.result_src = RES_PC4;
        end
        OP_JALR: begin
          ctrl.reg_write  = 1'b1;
          ctrl.jalr       = 1'b1;
          ctrl.alu_src    = 1'b1;
          ctrl.result_src = RES_PC4;
        end
        OP_LUI: begin
          ctrl.reg_write  = 1'b1;
          ctrl.alu_src    = 1'b1;
          ctrl.result_src = RES_IMM;
          ctrl.alu_ctrl   = ALU_PASSB;
        end
        OP_AUIPC: begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_src   = 1'b1;
        end
        default: ctrl.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_unit_pipe.sv
// ID-stage control unit: decode, ID/EX control register with flush/stall, MDU issue FSM.
module ctrl_unit_pipe
  import rv_ctrl_pkg::*;
#(
  parameter int ENABLE_M  = 1,
  parameter int ALUCTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  ctrl_unit_pipe_if.slave   bus
);

  ctrl_t    dec_ctrl;
  imm_src_e dec_imm;
  logic     dec_is_m;
  logic     mdu_start_w;
  ctrl_t    ctrl_q;
  ctrl_t    ctrl_d;

  ctrl_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .valid   (bus.ValidD),
    .op      (bus.OpD),
    .funct3  (bus.funct3D),
    .funct7  (bus.funct7D),
    .ctrl    (dec_ctrl),
    .imm_src (dec_imm),
    .is_m    (dec_is_m)
  );

  assign bus.ImmSrcD = dec_imm;

  generate
    if (ENABLE_M != 0) begin : g_mdu
      mdu_state_e state_q;
      mdu_state_e state_d;

      // An M op issues only from IDLE and only when it will actually enter E.
      assign mdu_start_w   = (state_q == MDU_IDLE) & bus.ValidD & dec_is_m & ~bus.StallE & ~bus.FlushE;
      assign bus.mdu_abort = (state_q == MDU_BUSY) & bus.FlushE;
      assign bus.stall_req = (state_q == MDU_BUSY) & ~bus.mdu_done;

      // Next state: a flush kills the op even if it completes in the same cycle.
      always_comb begin
        state_d = state_q;
        case (state_q)
          MDU_IDLE: if (mdu_start_w) state_d = MDU_BUSY;
          MDU_BUSY: if (bus.FlushE || bus.mdu_done) state_d = MDU_IDLE;
          default:  state_d = MDU_IDLE;
        endcase
      end

      // FSM state register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= MDU_IDLE;
        else     state_q <= state_d;
      end
    end else begin : g_no_mdu
      assign mdu_start_w   = 1'b0;
      assign bus.mdu_abort = 1'b0;
      assign bus.stall_req = 1'b0;
    end
  endgenerate

  assign bus.mdu_start = mdu_start_w;
  assign bus.mdu_op    = mdu_start_w ? bus.funct3D : 3'b000;

  // E-register input: flush beats stall beats load; an M op that cannot issue enters as a bubble.
  always_comb begin
    ctrl_d = dec_ctrl;
    if (bus.FlushE)                    ctrl_d = '0;
    else if (bus.StallE)               ctrl_d = ctrl_q;
    else if (dec_is_m && !mdu_start_w) ctrl_d = '0;
  end

  // ID/EX control register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ctrl_q <= '0;
    else     ctrl_q <= ctrl_d;
  end

  assign bus.RegWriteE   = ctrl_q.reg_write;
  assign bus.MemWriteE   = ctrl_q.mem_write;
  assign bus.BranchE     = ctrl_q.branch;
  assign bus.JumpE       = ctrl_q.jump;
  assign bus.JalrE       = ctrl_q.jalr;
  assign bus.ALUSrcE     = ctrl_q.alu_src;
  assign bus.MduE        = ctrl_q.mdu;
  assign bus.IllegalE    = ctrl_q.illegal;
  assign bus.ResultSrcE  = ctrl_q.result_src;
  assign bus.ALUControlE = ALUCTRL_W'(ctrl_q.alu_ctrl);

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Scoreboard bench: two instances (M enabled / disabled) driven with the same directed vectors.
module tb_ctrl_unit_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ctrl_unit_pipe_if #(.ALUCTRL_W(4)) bm ();
  ctrl_unit_pipe_if #(.ALUCTRL_W(4)) b0 ();

  ctrl_unit_pipe #(.ENABLE_M(1), .ALUCTRL_W(4)) dut_m (.clk(clk), .rst(rst), .bus(bm.slave));
  ctrl_unit_pipe #(.ENABLE_M(0), .ALUCTRL_W(4)) dut_0 (.clk(clk), .rst(rst), .bus(b0.slave));

  // Observation layout: {rw,mw,br,j,jalr,alusrc,mdu,ill}[22:15] rs[14:13] alu[12:9] imm[8:6] start[5] op[4:2] abort[1] stall[0]
  logic [22:0] obs [2];
  assign obs[0] = {bm.RegWriteE, bm.MemWriteE, bm.BranchE, bm.JumpE, bm.JalrE, bm.ALUSrcE, bm.MduE, bm.IllegalE,
                   bm.ResultSrcE, bm.ALUControlE, bm.ImmSrcD, bm.mdu_start, bm.mdu_op, bm.mdu_abort, bm.stall_req};
  assign obs[1] = {b0.RegWriteE, b0.MemWriteE, b0.BranchE, b0.JumpE, b0.JalrE, b0.ALUSrcE, b0.MduE, b0.IllegalE,
                   b0.ResultSrcE, b0.ALUControlE, b0.ImmSrcD, b0.mdu_start, b0.mdu_op, b0.mdu_abort, b0.stall_req};

  localparam logic [22:0] M_ALL = 23'h7FFFFF;
  localparam logic [22:0] M_E   = 23'h7FFE00;
  localparam logic [22:0] M_IMM = 23'h0001C0;
  localparam logic [22:0] M_MDU = 23'h00003F;
  localparam logic [22:0] M_AS  = 23'h000003;

  typedef struct {
    int          inst;
    int          due;
    string       name;
    logic [22:0] v;
    logic [22:0] m;
  } sb_t;
  sb_t sbq[$];

  function automatic logic [22:0] ev(input logic [7:0] f, input logic [1:0] rs, input logic [3:0] alu);
    return {f, rs, alu, 9'd0};
  endfunction

  function automatic logic [22:0] cv(input logic [2:0] imm, input logic st, input logic [2:0] op,
                                     input logic ab, input logic sr);
    return {14'd0, imm, st, op, ab, sr};
  endfunction

  task automatic sb_push(input int inst, input int due, input string nm, input logic [22:0] v, input logic [22:0] m);
    sb_t e;
    e.inst = inst; e.due = due; e.name = nm; e.v = v; e.m = m;
    sbq.push_back(e);
  endtask

  // Monitor: every falling edge, compare all expectations due in this cycle.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due == cyc) begin
        vectors++;
        if ((obs[sbq[i].inst] & sbq[i].m) !== (sbq[i].v & sbq[i].m)) begin
          miscompares++;
          $display("FAIL %s (%s, cyc %0d): got %h, expected %h (mask %h)", sbq[i].name,
                   (sbq[i].inst == 0) ? "M=1" : "M=0", cyc, obs[sbq[i].inst] & sbq[i].m,
                   sbq[i].v & sbq[i].m, sbq[i].m);
        end else begin
          $display("ok   %s (%s, cyc %0d): %h", sbq[i].name, (sbq[i].inst == 0) ? "M=1" : "M=0",
                   cyc, obs[sbq[i].inst] & sbq[i].m);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic st, input logic fl, input logic dn);
    bm.ValidD = v; bm.OpD = op; bm.funct3D = f3; bm.funct7D = f7;
    bm.StallE = st; bm.FlushE = fl; bm.mdu_done = dn;
    b0.ValidD = v; b0.OpD = op; b0.funct3D = f3; b0.funct7D = f7;
    b0.StallE = st; b0.FlushE = fl; b0.mdu_done = dn;
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      name;
    logic       v;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [7:0] fl;
    logic [1:0] rs;
    logic [3:0] alu;
    logic [2:0] imm;
  } dv_t;
  dv_t tab[16];

  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] I = 7'b0010011;

  int k;

  initial begin
    tab[0]  = '{"ADD",    1'b1, R,        3'b000, 7'h00, 8'h80, 2'd0, 4'd0,  3'b000};
    tab[1]  = '{"SUB",    1'b1, R,        3'b000, 7'h20, 8'h80, 2'd0, 4'd1,  3'b000};
    tab[2]  = '{"SRA",    1'b1, R,        3'b101, 7'h20, 8'h80, 2'd0, 4'd9,  3'b000};
    tab[3]  = '{"SLL_f7", 1'b1, R,        3'b001, 7'h20, 8'h01, 2'd0, 4'd0,  3'b000};
    tab[4]  = '{"BADOP",  1'b1, 7'h7F,    3'b000, 7'h00, 8'h01, 2'd0, 4'd0,  3'b000};
    tab[5]  = '{"BUBBLE", 1'b0, R,        3'b000, 7'h00, 8'h00, 2'd0, 4'd0,  3'b000};
    tab[6]  = '{"ADDI",   1'b1, I,        3'b000, 7'h20, 8'h84, 2'd0, 4'd0,  3'b000};
    tab[7]  = '{"SRAI",   1'b1, I,        3'b101, 7'h20, 8'h84, 2'd0, 4'd9,  3'b000};
    tab[8]  = '{"LW",     1'b1, 7'h03,    3'b010, 7'h00, 8'h84, 2'd1, 4'd0,  3'b000};
    tab[9]  = '{"SW",     1'b1, 7'h23,    3'b010, 7'h00, 8'h44, 2'd0, 4'd0,  3'b001};
    tab[10] = '{"BNE",    1'b1, 7'h63,    3'b001, 7'h00, 8'h20, 2'd0, 4'd1,  3'b010};
    tab[11] = '{"JAL",    1'b1, 7'h6F,    3'b000, 7'h00, 8'h90, 2'd2, 4'd0,  3'b011};
    tab[12] = '{"AUIPC",  1'b1, 7'h17,    3'b000, 7'h00, 8'h84, 2'd0, 4'd0,  3'b100};
    tab[13] = '{"SLT",    1'b1, R,        3'b010, 7'h00, 8'h80, 2'd0, 4'd5,  3'b000};
    tab[14] = '{"XORI",   1'b1, I,        3'b100, 7'h7F, 8'h84, 2'd0, 4'd4,  3'b000};
    tab[15] = '{"JALR",   1'b1, 7'h67,    3'b000, 7'h00, 8'h8C, 2'd2, 4'd0,  3'b000};

    drive(1'b0, 7'h00, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    k = cyc;
    sb_push(0, k, "reset", 23'd0, M_ALL);
    sb_push(1, k, "reset", 23'd0, M_ALL);
    nx();
    rst = 1'b0;

    // Decode table: controls appear in E one cycle after presentation; ImmSrcD immediately.
    foreach (tab[i]) begin
      nx();
      drive(tab[i].v, tab[i].op, tab[i].f3, tab[i].f7, 1'b0, 1'b0, 1'b0);
      k = cyc;
      sb_push(0, k + 1, tab[i].name, ev(tab[i].fl, tab[i].rs, tab[i].alu), M_E);
      sb_push(1, k + 1, tab[i].name, ev(tab[i].fl, tab[i].rs, tab[i].alu), M_E);
      sb_push(0, k, {tab[i].name, "_imm"}, cv(tab[i].imm, 1'b0, 3'b000, 1'b0, 1'b0), M_IMM);
    end

    // MULH: illegal without M; issued with M, then BUSY until done four cycles later.
    nx(); drive(1'b1, R, 3'b001, 7'h01, 1'b0, 1'b0, 1'b0); k = cyc;
    sb_push(0, k, "mulh_start", cv(3'b000, 1'b1, 3'b001, 1'b0, 1'b0), M_MDU);
    sb_push(1, k, "mulh_nostart", 23'd0, M_MDU);
    sb_push(0, k + 1, "mulh_E", ev(8'h82, 2'd0, 4'd0), M_E);
    sb_push(1, k + 1, "mulh_illegal", ev(8'h01, 2'd0, 4'd0), M_E);
    sb_push(0, k + 1, "busy1_stall", cv(3'b000, 1'b0, 3'b000, 1'b0, 1'b1), M_AS);
    nx(); drive(1'b0, R, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0);
    nx(); drive(1'b1, R, 3'b100, 7'h01, 1'b0, 1'b0, 1'b0); k = cyc;
    sb_push(0, k, "div_in_busy", cv(3'b000, 1'b0, 3'b000, 1'b0, 1'b1), M_MDU);
    sb_push(0, k + 1, "div_in_busy_E", 23'd0, M_E);
    sb_push(0, k + 1, "busy3_stall", cv(3'b000, 1'b0, 3'b000, 1'b0, 1'b1), M_AS);
    nx(); drive(1'b0, R, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0);
    nx(); drive(1'b0, R, 3'b000, 7'h00, 1'b0, 1'b0, 1'b1); k = cyc;
    sb_push(0, k, "done_cycle", cv(3'b000, 1'b0, 3'b000, 1'b0, 1'b0), M_AS);
    nx(); drive(1'b1, R, 3'b100, 7'h01, 1'b0, 1'b0, 1'b0); k = cyc;
    sb_push(0, k, "div_after_idle", cv(3'b000, 1'b1, 3'b100, 1'b0, 1'b0), M_MDU);
    sb_push(0, k + 1, "div_E", ev(8'h82, 2'd0, 4'd0), M_E);

    // Flush coinciding with done: abort wins, E takes a bubble, FSM idles.
    nx(); drive(1'b0, R, 3'b000, 7'h00, 1'b0, 1'b1, 1'b1); k = cyc;
    sb_push(0, k, "flush_done_abort", cv(3'b000, 1'b0, 3'b000, 1'b1, 1'b0), M_AS);
    sb_push(1, k, "flush_done_noM", 23'd0, M_MDU);
    sb_push(0, k + 1, "flush_bubble", 23'd0, M_E);
    sb_push(0, k + 1, "after_abort", 23'd0, M_AS);
    nx(); drive(1'b0, R, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0);
    nx(); drive(1'b1, R, 3'b000, 7'h01, 1'b0, 1'b0, 1'b0); k = cyc;
    sb_push(0, k, "mul_start", cv(3'b000, 1'b1, 3'b000, 1'b0, 1'b0), M_MDU);
    nx(); drive(1'b0, R, 3'b000, 7'h00, 1'b0, 1'b1, 1'b0); k = cyc;
    sb_push(0, k, "flush_abort", cv(3'b000, 1'b0, 3'b000, 1'b1, 1'b1), M_AS);
    sb_push(0, k + 1, "after_abort2", 23'd0, M_AS);
    nx(); drive(1'b0, R, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0);

    // StallE holds E across a waiting LUI; an M op under StallE is not issued.
    nx(); drive(1'b1, R, 3'b000, 7'h20, 1'b0, 1'b0, 1'b0); k = cyc;
    sb_push(0, k + 1, "pre_sub", ev(8'h80, 2'd0, 4'd1), M_E);
    nx(); drive(1'b1, 7'h37, 3'b000, 7'h00, 1'b1, 1'b0, 1'b0); k = cyc;
    sb_push(1, k, "lui_imm", cv(3'b100, 1'b0, 3'b000, 1'b0, 1'b0), M_IMM);
    sb_push(0, k + 1, "stall_hold1", ev(8'h80, 2'd0, 4'd1), M_E);
    sb_push(1, k + 1, "stall_hold1", ev(8'h80, 2'd0, 4'd1), M_E);
    nx(); drive(1'b1, 7'h37, 3'b000, 7'h00, 1'b1, 1'b0, 1'b0); k = cyc;
    sb_push(0, k + 1, "stall_hold2", ev(8'h80, 2'd0, 4'd1), M_E);
    nx(); drive(1'b1, 7'h37, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0); k = cyc;
    sb_push(0, k + 1, "lui_E", ev(8'h84, 2'd3, 4'd10), M_E);
    sb_push(1, k + 1, "lui_E", ev(8'h84, 2'd3, 4'd10), M_E);
    nx(); drive(1'b1, R, 3'b000, 7'h01, 1'b1, 1'b0, 1'b0); k = cyc;
    sb_push(0, k, "mul_stalled_nostart", 23'd0, M_MDU);
    sb_push(0, k + 1, "mul_stalled_E", ev(8'h84, 2'd3, 4'd10), M_E);

    // Reset while BUSY (with FlushE high): everything clears, no abort pulse.
    nx(); drive(1'b1, R, 3'b011, 7'h01, 1'b0, 1'b0, 1'b0); k = cyc;
    sb_push(0, k, "mulhu_start", cv(3'b000, 1'b1, 3'b011, 1'b0, 1'b0), M_MDU);
    nx(); drive(1'b0, 7'h00, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0); k = cyc;
    sb_push(0, k, "busy_before_rst", cv(3'b000, 1'b0, 3'b000, 1'b0, 1'b1), M_AS);
    nx(); rst = 1'b1; drive(1'b0, 7'h00, 3'b000, 7'h00, 1'b0, 1'b1, 1'b0); k = cyc;
    sb_push(0, k, "rst_mid_busy", 23'd0, M_ALL);
    nx(); rst = 1'b0; drive(1'b1, R, 3'b010, 7'h01, 1'b0, 1'b0, 1'b0); k = cyc;
    sb_push(0, k, "start_after_rst", cv(3'b000, 1'b1, 3'b010, 1'b0, 1'b0), M_MDU);
    nx(); drive(1'b0, 7'h00, 3'b000, 7'h00, 1'b0, 1'b0, 1'b1);
    repeat (3) nx();

    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ctrl_unit_pipe.md
# ctrl_unit_pipe

Parametrised successor to the single-cycle RV32I control decoder. It decodes Op/funct3/funct7 in ID and adds full RV32I ALU coverage, illegal-instruction detection and optional M-extension dispatch. It registers the control bundle into the ID/EX boundary with stall/flush handling. When M is enabled, a two-state FSM hands MUL/DIV ops to an external multi-cycle unit and holds the front end until it completes. It sits between the IF/ID register and the Execute stage.

## Interface
- `ENABLE_M`, 0, 1 = decode the M extension (Op 0110011, funct7 0000001) and drive the MDU handshake; 0 = such encodings are illegal.
- `ALUCTRL_W`, 4, ALUControl width; must be ≥4.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ValidD`  in  1  the ID-stage instruction is real, not a bubble.
- `OpD`  in  7  opcode.
- `funct3D`  in  3  funct3 field.
- `funct7D`  in  7  funct7 field.
- `StallE`  in  1  hold the E register; from the hazard unit.
- `FlushE`  in  1  load a bubble into the E register.
- `mdu_done`  in  1  one-cycle pulse from the MDU: result ready.
- `RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, MduE, IllegalE`  out  1 each  registered controls.
- `ResultSrcE`  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate.
- `ImmSrcD`  out  3  combinational, for the ID-stage extender: I=000, S=001, B=010, J=011, U=100.
- `ALUControlE`  out  ALUCTRL_W  ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, PASSB 10; zero-extended.
- `mdu_start`  out  1  one-cycle issue pulse.
- `mdu_op`  out  3  funct3 of the issued M op.
- `mdu_abort`  out  1  one-cycle pulse when a busy MDU op is killed.
- `stall_req`  out  1  front-end stall request to the hazard unit.

## Operation
- Decoded opcodes:
  - R 0110011, I-ALU 0010011, Load 0000011, Store 0100011, Branch 1100011.
  - JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Any other opcode → IllegalE=1 with all other controls 0.
- funct7 rules:
  - R-type: funct7 must be 0000000, or 0100000 for SUB/SRA only.
  - I-type SLLI/SRLI/SRAI follow the same rule on funct7.
  - Violations are illegal.
- ALU selection:
  - Branches use SUB; the branch unit reads funct3 separately.
  - Load/Store/JALR/AUIPC use ADD.
  - LUI uses PASSB with ResultSrc=11.
- ValidD=0 decodes as a bubble: all controls 0.
- Bubble = every E output 0.
- MDU FSM, states IDLE and BUSY (ENABLE_M=1 only):
  - IDLE→BUSY when ValidD and the instruction is an M op, with StallE=0 and FlushE=0. mdu_start=1 and mdu_op=funct3D in that cycle; the op enters E with MduE=1 and RegWriteE=1.
  - BUSY: stall_req = ~mdu_done (combinational).
  - BUSY→IDLE on mdu_done.
  - BUSY→IDLE on FlushE with mdu_abort=1 in that cycle. If mdu_done and FlushE coincide, abort wins: mdu_abort=1 and the result is discarded.
  - A new M op in ID while BUSY is not issued until the FSM returns to IDLE.
- With ENABLE_M=0: the FSM is absent, and mdu_start, mdu_abort, stall_req and MduE are tied to 0.

## Timing
- Reset: all E outputs, mdu_* and stall_req are 0; FSM in IDLE.
- Reset asserted mid-BUSY: immediate return to IDLE with no abort pulse.
- E register priority: rst > FlushE (bubble) > StallE (hold) > load from ID. Latency is 1 cycle from ID to E.
- ImmSrcD is combinational, with zero latency.
- In the issue cycle, mdu_start is combinational from ID and is gated by ~StallE & ~FlushE.

## Structure
- Shared package `rv_ctrl_pkg`:
  - opcode constants
  - ALU op codes
  - ImmSrc and ResultSrc encodings
  - M funct7 constant
  - FSM state enum
- Natural sub-module `ctrl_decode`: pure combinational decode producing the bundle plus an is_m flag.
- The top level holds the E register and the FSM.

## Test plan
- Reset mid-BUSY: assert rst → all outputs 0 next sample; no mdu_abort.
- ADD then SUB, then SRA with funct7 0100000 → ALUControlE 0, 1, 9, each 1 cycle after presentation.
- R-type with funct7 0000001 and ENABLE_M=0 → IllegalE=1, RegWriteE=0; same instruction with ENABLE_M=1 → mdu_start pulse, mdu_op=funct3, MduE=1.
- MUL issued, mdu_done 4 cycles later → stall_req high for cycles 1–3 after issue, low on the done cycle, FSM back in IDLE.
- FlushE in BUSY concurrent with mdu_done → mdu_abort=1, E register holds a bubble, stall_req=0 next cycle.
- StallE=1 for 2 cycles while a LUI sits in ID → E keeps the prior instruction's controls; then ALUControlE=10, ResultSrcE=11.
